mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the core's single-port memory (address/data_out/we/data_in) between two requesters:
//  port 0 = core, port 1 = loader/DMA.
//  Sits between the requesters and the memory. Issues one transaction at a time.
//  Uses a req/gnt handshake and returns read data with a one-cycle rvalid pulse.
//  Arbitration is round-robin by default.
// PARAMETERS
//  AW            32  address width
//  DW            32  data width
//  READ_LATENCY  1   memory cycles from address capture to valid mem_data_in (>=1)
// PORTS
//  clk          in   1   clock, all logic on posedge
//  resetn       in   1   reset, synchronous, active-low
//  m0_req       in   1   port 0 request; m0_we/m0_addr/m0_wdata held stable until m0_gnt
//  m0_we        in   1   port 0 write enable (1=write, 0=read)
//  m0_addr      in   AW  port 0 address
//  m0_wdata     in   DW  port 0 write data
//  m0_gnt       out  1   port 0 accepted, one-cycle pulse
//  m0_rvalid    out  1   port 0 read data valid, one-cycle pulse
//  m0_rdata     out  DW  port 0 read data, valid while m0_rvalid
//  m1_*         same set as m0_* for port 1
//  mem_address  out  AW  memory address
//  mem_data_out out  DW  memory write data
//  mem_we       out  1   memory write enable
//  mem_data_in  in   DW  memory read data
// BEHAVIOUR
//  - Reset (resetn=0 at posedge): state=IDLE, all outputs 0, last_grant=1 (port 0 wins first tie).
//  - FSM states:
//    - IDLE: requests are sampled only here.
//      - No req: stay IDLE.
//      - Else pick winner, latch its addr/we/wdata into mem_*, assert its gnt, go to ISSUE.
//    - ISSUE (1 cycle): mem_we = winner's we, gnt=1. Next edge -> WAIT with cnt=READ_LATENCY.
//      Clears gnt and mem_we.
//    - WAIT: cnt decrements each cycle.
//      - At the edge where cnt==1: a read captures mem_data_in into mX_rdata and pulses
//        mX_rvalid for 1 cycle; a write produces no rvalid. Go to IDLE.
//  - Latency (LAT=1): req sampled at E0 -> gnt/mem_* valid E0..E1 -> rvalid E2..E3.
//    Next sample at E3. Max one transaction per 2+READ_LATENCY cycles.
//  - mem_we high exactly one cycle per write, never for reads.
//  - mem_address/mem_data_out hold their last issued value outside ISSUE.
//  - Round-robin: both req in IDLE -> grant the port != last_grant.
//    last_grant updates on every grant. Single req -> grant it regardless.
//  - A port whose req drops before being granted is simply not served. No partial state.
//  - A req held high after gnt is treated as a new request at the next IDLE sample.
//  - Only the winner's gnt/rvalid ever assert. Never both ports in the same cycle.
//  - mX_rdata holds its value until the next rvalid on that port.
//  - Reset mid-transaction (ISSUE/WAIT): abort. No rvalid, mem_we=0 next cycle, state IDLE.
//  - No address/data arithmetic; widths pass through unchanged.
// CONFIGURATION
//  MEM_ARB_FIXED_PRIORITY_EN
//  - Defined: port 0 always wins when both request. last_grant is unused.
//    Port 1 may starve; this is acceptable only while the loader runs with the core in reset.
//  - Undefined (default): round-robin as above.
// TESTING
//  1. Reset: resetn=0 for 2 cycles with both req=1 -> all outputs 0, no gnt.
//     First IDLE after release grants m0.
//  2. m0 read addr=0x10, mem returns 0xDEADBEEF (LAT=1)
//     -> m0_gnt at cycle 1, mem_we=0, m0_rvalid=1 with m0_rdata=0xDEADBEEF at cycle 3.
//  3. m1 write addr=0x20 data=0x12345678
//     -> mem_we=1 for exactly 1 cycle with mem_address=0x20, mem_data_out=0x12345678.
//     No m1_rvalid.
//  4. Both req held high for 4 transactions -> grants alternate m0,m1,m0,m1.
//     With MEM_ARB_FIXED_PRIORITY_EN: m0 x4.
//  5. resetn=0 during WAIT of an m0 read -> no m0_rvalid, state IDLE, mem_we=0.
//  6. READ_LATENCY=3, m0 read -> m0_rvalid exactly 3 cycles after the ISSUE cycle ends.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - two requester ports plus single-port memory bus for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_out;
    logic          mem_we;
    logic [DW-1:0] mem_data_in;

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_address, mem_data_out, mem_we,
        input  mem_data_in
    );

    // Requester / memory-model side
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_address, mem_data_out, mem_we,
        output mem_data_in
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port arbiter onto single-port memory (round-robin; MEM_ARB_FIXED_PRIORITY_EN gives port 0 fixed priority)
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                resetn,
    mem_port_arbiter_if.slave   bus
);
    localparam int CW = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          sel, sel_n;
    logic          wr, wr_n;
    logic          pick;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] data_n;
    logic          we_n;
    logic          g0_n, g1_n, v0_n, v1_n;
    logic [DW-1:0] rd0_n, rd1_n;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
    logic          last_grant, last_grant_n;
`endif

    // Next-state and next-output computation; requests are looked at only in IDLE
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sel_n   = sel;
        wr_n    = wr;
        addr_n  = bus.mem_address;
        data_n  = bus.mem_data_out;
        we_n    = 1'b0;
        g0_n    = 1'b0;
        g1_n    = 1'b0;
        v0_n    = 1'b0;
        v1_n    = 1'b0;
        rd0_n   = bus.m0_rdata;
        rd1_n   = bus.m1_rdata;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
        // Port 0 always wins a tie; port 1 only when port 0 is quiet
        pick = !bus.m0_req;
`else
        last_grant_n = last_grant;
        // Tie goes to the port that did not win last time
        pick = (bus.m0_req && bus.m1_req) ? ~last_grant : bus.m1_req;
`endif
        case (state)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    sel_n  = pick;
                    wr_n   = pick ? bus.m1_we    : bus.m0_we;
                    addr_n = pick ? bus.m1_addr  : bus.m0_addr;
                    data_n = pick ? bus.m1_wdata : bus.m0_wdata;
                    we_n   = wr_n;
                    g0_n   = !pick;
                    g1_n   = pick;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
                    last_grant_n = pick;
`endif
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                cnt_n   = CW'(READ_LATENCY);
                state_n = WAIT;
            end
            WAIT: begin
                if (cnt == CW'(1)) begin
                    if (!wr) begin
                        if (sel) begin
                            v1_n  = 1'b1;
                            rd1_n = bus.mem_data_in;
                        end else begin
                            v0_n  = 1'b1;
                            rd0_n = bus.mem_data_in;
                        end
                    end
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state            <= IDLE;
            cnt              <= '0;
            sel              <= 1'b0;
            wr               <= 1'b0;
            bus.mem_address  <= '0;
            bus.mem_data_out <= '0;
            bus.mem_we       <= 1'b0;
            bus.m0_gnt       <= 1'b0;
            bus.m1_gnt       <= 1'b0;
            bus.m0_rvalid    <= 1'b0;
            bus.m1_rvalid    <= 1'b0;
            bus.m0_rdata     <= '0;
            bus.m1_rdata     <= '0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
            last_grant       <= 1'b1;
`endif
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            sel              <= sel_n;
            wr               <= wr_n;
            bus.mem_address  <= addr_n;
            bus.mem_data_out <= data_n;
            bus.mem_we       <= we_n;
            bus.m0_gnt       <= g0_n;
            bus.m1_gnt       <= g1_n;
            bus.m0_rvalid    <= v0_n;
            bus.m1_rvalid    <= v1_n;
            bus.m0_rdata     <= rd0_n;
            bus.m1_rdata     <= rd1_n;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
            last_grant       <= last_grant_n;
`endif
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic resetn;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) if1 ();
    mem_port_arbiter_if #(.AW(32), .DW(32)) if3 ();

    mem_port_arbiter #(.AW(32), .DW(32), .READ_LATENCY(1)) dut1 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (if1)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .READ_LATENCY(3)) dut3 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (if3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        int  n;
        logic [3:0] order;
        logic [3:0] exp_order;

        resetn = 1'b0;
        if1.m0_req = 1'b1; if1.m0_we = 1'b0; if1.m0_addr = 32'h10; if1.m0_wdata = 32'h0;
        if1.m1_req = 1'b1; if1.m1_we = 1'b1; if1.m1_addr = 32'h20; if1.m1_wdata = 32'h12345678;
        if1.mem_data_in = 32'hDEADBEEF;
        if3.m0_req = 1'b0; if3.m0_we = 1'b0; if3.m0_addr = 32'h0; if3.m0_wdata = 32'h0;
        if3.m1_req = 1'b0; if3.m1_we = 1'b0; if3.m1_addr = 32'h0; if3.m1_wdata = 32'h0;
        if3.mem_data_in = 32'hCAFEF00D;

        // Reset held two cycles with both requests high
        tick();
        tick();
        check("rst_gnt", {if1.m0_gnt, if1.m1_gnt}, 2'b00);
        check("rst_rvalid", {if1.m0_rvalid, if1.m1_rvalid}, 2'b00);
        check("rst_mem_we", if1.mem_we, 1'b0);
        check("rst_mem_addr", if1.mem_address, 32'h0);
        check("rst_rdata", {if1.m0_rdata, if1.m1_rdata}, 64'h0);
        resetn = 1'b1;

        // First IDLE sample: tie goes to m0, read of 0x10
        tick();
        check("rd_m0_gnt", {if1.m0_gnt, if1.m1_gnt}, 2'b10);
        check("rd_mem_we", if1.mem_we, 1'b0);
        check("rd_mem_addr", if1.mem_address, 32'h10);
        if1.m0_req = 1'b0;
        tick();
        check("rd_gnt_clear", {if1.m0_gnt, if1.m0_rvalid}, 2'b00);
        tick();
        check("rd_rvalid", {if1.m0_rvalid, if1.m1_rvalid}, 2'b10);
        check("rd_rdata", if1.m0_rdata, 32'hDEADBEEF);
        check("rd_no_gnt_in_wait", if1.m1_gnt, 1'b0);

        // m1 write of 0x12345678 to 0x20
        tick();
        check("wr_rvalid_drop", if1.m0_rvalid, 1'b0);
        check("wr_m1_gnt", {if1.m0_gnt, if1.m1_gnt}, 2'b01);
        check("wr_mem_we", if1.mem_we, 1'b1);
        check("wr_mem_addr", if1.mem_address, 32'h20);
        check("wr_mem_data", if1.mem_data_out, 32'h12345678);
        if1.m1_req = 1'b0;
        tick();
        check("wr_mem_we_1cyc", if1.mem_we, 1'b0);
        check("wr_addr_hold", if1.mem_address, 32'h20);
        tick();
        check("wr_no_rvalid_a", if1.m1_rvalid, 1'b0);
        tick();
        check("wr_no_rvalid_b", {if1.m1_rvalid, if1.m0_gnt, if1.m1_gnt}, 3'b000);
        check("rdata_hold", if1.m0_rdata, 32'hDEADBEEF);

        // Both requests held for four transactions
        if1.m0_we = 1'b0; if1.m0_addr = 32'h100;
        if1.m1_we = 1'b0; if1.m1_addr = 32'h200;
        if1.m0_req = 1'b1; if1.m1_req = 1'b1;
        order = 4'b0000;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            do begin
                tick();
                n++;
                if (if1.m0_gnt && if1.m1_gnt) check("rr_both_gnt", 2'b11, 2'b00);
                if (if1.m0_rvalid && if1.m1_rvalid) check("rr_both_rvalid", 2'b11, 2'b00);
            end while (!if1.m0_gnt && !if1.m1_gnt && n < 10);
            check("rr_gnt_timeout", (n < 10), 1'b1);
            order[t] = if1.m1_gnt;
        end
`ifdef MEM_ARB_FIXED_PRIORITY_EN
        exp_order = 4'b0000;
`else
        exp_order = 4'b1010;
`endif
        check("rr_order", order, exp_order);
        if1.m0_req = 1'b0; if1.m1_req = 1'b0;
        for (int t = 0; t < 4; t++) tick();

        // Reset during WAIT of an m0 read
        if1.m0_addr = 32'h30;
        if1.m0_req = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!if1.m0_gnt && n < 10);
        check("abort_gnt_timeout", (n < 10), 1'b1);
        if1.m0_req = 1'b0;
        tick();
        resetn = 1'b0;
        tick();
        check("abort_no_rvalid", {if1.m0_rvalid, if1.m1_rvalid}, 2'b00);
        check("abort_mem_we", if1.mem_we, 1'b0);
        resetn = 1'b1;
        tick();
        check("abort_still_no_rvalid", if1.m0_rvalid, 1'b0);
        if1.m0_req = 1'b1; if1.m1_req = 1'b1;
        tick();
        check("abort_idle_m0_wins", {if1.m0_gnt, if1.m1_gnt}, 2'b10);
        if1.m0_req = 1'b0; if1.m1_req = 1'b0;

        // READ_LATENCY=3 read: rvalid three cycles after ISSUE ends
        if3.m0_addr = 32'h40;
        if3.m0_req = 1'b1;
        tick();
        check("lat3_gnt", if3.m0_gnt, 1'b1);
        if3.m0_req = 1'b0;
        tick();
        check("lat3_e1", if3.m0_rvalid, 1'b0);
        tick();
        check("lat3_e2", if3.m0_rvalid, 1'b0);
        tick();
        check("lat3_e3", if3.m0_rvalid, 1'b0);
        tick();
        check("lat3_rvalid", if3.m0_rvalid, 1'b1);
        check("lat3_rdata", if3.m0_rdata, 32'hCAFEF00D);
        tick();
        check("lat3_rvalid_drop", if3.m0_rvalid, 1'b0);
        check("lat3_rdata_hold", if3.m0_rdata, 32'hCAFEF00D);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
